// File: rtl/coolgirl_irq_timer_if.sv
// Register-write bus between the mapper decode and the IRQ timer, plus the IRQ outputs.
// reg_we is a one-cycle strobe per CPU write with no ready: every write is accepted on the m2 edge it is high.
interface coolgirl_irq_timer_if #(
  parameter int CHANNELS = 2,
  parameter int CH_W     = 1
);
  logic                reg_we;
  logic [CH_W-1:0]     reg_ch;
  logic [2:0]          reg_sel;
  logic [7:0]          reg_data;
  logic [CHANNELS-1:0] irq_pending;
  logic                irq_out;

  modport master (
    output reg_we, reg_ch, reg_sel, reg_data,
    input  irq_pending, irq_out
  );

  modport slave (
    input  reg_we, reg_ch, reg_sel, reg_data,
    output irq_pending, irq_out
  );
endinterface

// File: rtl/coolgirl_irq_timer.sv
// Multi-channel M2-clocked IRQ timer: up/down, latch reload, one-shot/repeat per channel.
// Define IRQ_TIMER_PRESCALER_EN to build the VRC4-style scanline prescaler (control MODE bit).
module coolgirl_irq_timer #(
  parameter int CHANNELS = 2,
  parameter int WIDTH    = 16,
  parameter int CH_W     = 1
) (
  input  logic                  m2,
  input  logic                  rst_n,
  coolgirl_irq_timer_if.slave   bus
);

  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

  logic [WIDTH-1:0]    cnt_q   [CHANNELS];
  logic [WIDTH-1:0]    cnt_d   [CHANNELS];
  logic [WIDTH-1:0]    latch_q [CHANNELS];
  logic [WIDTH-1:0]    latch_d [CHANNELS];
  logic [CHANNELS-1:0] en_q, en_d;
  logic [CHANNELS-1:0] rep_q, rep_d;
  logic [CHANNELS-1:0] dir_q, dir_d;
  logic [CHANNELS-1:0] eaa_q, eaa_d;
  logic [CHANNELS-1:0] pend_q, pend_d;
`ifdef IRQ_TIMER_PRESCALER_EN
  localparam logic signed [9:0] PRE_RELOAD = 10'sd341;
  logic [CHANNELS-1:0] mode_q, mode_d;
  logic signed [9:0]   pres_q [CHANNELS];
  logic signed [9:0]   pres_d [CHANNELS];
`endif

  // Byte write into a WIDTH-bit register; high-byte bits above WIDTH fall away.
  function automatic logic [WIDTH-1:0] put_byte(input logic [WIDTH-1:0] v,
                                                input logic hi, input logic [7:0] b);
    logic [15:0] t;
    t = 16'(v);
    if (hi) t[15:8] = b;
    else    t[7:0]  = b;
    return t[WIDTH-1:0];
  endfunction

  always_comb begin
    cnt_d   = cnt_q;
    latch_d = latch_q;
    en_d    = en_q;
    rep_d   = rep_q;
    dir_d   = dir_q;
    eaa_d   = eaa_q;
    pend_d  = pend_q;
`ifdef IRQ_TIMER_PRESCALER_EN
    mode_d  = mode_q;
    pres_d  = pres_q;
`endif
    for (int i = 0; i < CHANNELS; i++) begin : g_ch
      logic hit;
      logic load_wr;
      logic tick;
      logic expire;
      hit     = bus.reg_we && (bus.reg_ch == CH_W'(i));
      load_wr = hit && (bus.reg_sel != 3'd3) && (bus.reg_sel <= 3'd5);
      tick    = en_q[i];
`ifdef IRQ_TIMER_PRESCALER_EN
      begin : g_pres
        logic signed [9:0] pres_step;
        pres_step = pres_q[i] - 10'sd3;
        if (en_q[i] && mode_q[i]) begin
          tick      = (pres_step <= 10'sd0);
          pres_d[i] = tick ? (pres_step + PRE_RELOAD) : pres_step;
        end
      end
`endif
      // A same-edge latch/counter/control write swallows the tick.
      expire = 1'b0;
      if (tick && !load_wr) begin
        expire = dir_q[i] ? (cnt_q[i] == ALL_ONES) : (cnt_q[i] == '0);
        if (expire) begin
          pend_d[i] = 1'b1;
          if (rep_q[i]) begin
            cnt_d[i] = latch_q[i];
          end else begin
            cnt_d[i] = dir_q[i] ? '0 : ALL_ONES;
            en_d[i]  = 1'b0;
          end
        end else begin
          cnt_d[i] = dir_q[i] ? (cnt_q[i] + WIDTH'(1)) : (cnt_q[i] - WIDTH'(1));
        end
      end
      if (hit) begin
        case (bus.reg_sel)
          3'd0: latch_d[i] = put_byte(latch_q[i], 1'b0, bus.reg_data);
          3'd1: latch_d[i] = put_byte(latch_q[i], 1'b1, bus.reg_data);
          3'd2: begin
            en_d[i]   = bus.reg_data[0];
            rep_d[i]  = bus.reg_data[1];
            dir_d[i]  = bus.reg_data[3];
            eaa_d[i]  = bus.reg_data[4];
            pend_d[i] = 1'b0;
`ifdef IRQ_TIMER_PRESCALER_EN
            mode_d[i] = bus.reg_data[2];
            pres_d[i] = PRE_RELOAD;
`endif
            if (bus.reg_data[0]) cnt_d[i] = latch_q[i];
          end
          // An expiry on the same edge outranks the acknowledge.
          3'd3: if (!expire) begin
            pend_d[i] = 1'b0;
            en_d[i]   = eaa_q[i];
          end
          3'd4: cnt_d[i] = put_byte(cnt_q[i], 1'b0, bus.reg_data);
          3'd5: cnt_d[i] = put_byte(cnt_q[i], 1'b1, bus.reg_data);
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge m2 or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_q[i]   <= '0;
        latch_q[i] <= '0;
`ifdef IRQ_TIMER_PRESCALER_EN
        pres_q[i]  <= PRE_RELOAD;
`endif
      end
      en_q   <= '0;
      rep_q  <= '0;
      dir_q  <= '0;
      eaa_q  <= '0;
      pend_q <= '0;
`ifdef IRQ_TIMER_PRESCALER_EN
      mode_q <= '0;
`endif
    end else begin
      cnt_q   <= cnt_d;
      latch_q <= latch_d;
      en_q    <= en_d;
      rep_q   <= rep_d;
      dir_q   <= dir_d;
      eaa_q   <= eaa_d;
      pend_q  <= pend_d;
`ifdef IRQ_TIMER_PRESCALER_EN
      mode_q  <= mode_d;
      pres_q  <= pres_d;
`endif
    end
  end

  assign bus.irq_pending = pend_q;
  assign bus.irq_out     = |pend_q;

endmodule
